// File: rtl/sdram_pkg.sv
// Shared types and constants for the PowerPC-to-SDRAM controller.
// SDRAM_PARITY_EN widens DQ to nine bits with an even-parity bit.
package sdram_pkg;

  localparam int ROW_W = 12;
  localparam int COL_W = 9;

`ifdef SDRAM_PARITY_EN
  localparam int DQ_W = 9;
`else
  localparam int DQ_W = 8;
`endif

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    ACT  = 4'd1,
    COL  = 4'd2,
    WR   = 4'd3,
    CLW  = 4'd4,
    PRE  = 4'd5,
    REF  = 4'd6,
    RFW  = 4'd7
  } state_e;

  // {CS,RAS,CAS,WE}, all active-high
  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_NOP      = 4'b0000;
  localparam cmd_t CMD_ACTIVATE = 4'b1100;
  localparam cmd_t CMD_READ     = 4'b1110;
  localparam cmd_t CMD_WRITE    = 4'b1111;
  localparam cmd_t CMD_REFRESH  = 4'b1010;
  localparam cmd_t CMD_WDATA    = 4'b1001;
  localparam cmd_t CMD_WAIT     = 4'b1000;

  function automatic logic even_par(input logic [0:7] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sdram_ref_timer.sv
// Free-running refresh interval timer with a sticky pending flag.
// The flag stays set until the controller enters its refresh state.
module sdram_ref_timer #(
  parameter int REF_PERIOD = 780
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic ref_pend
);

  localparam int CW = $clog2(REF_PERIOD + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REF_PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= RELOAD;
      ref_pend <= 1'b0;
    end else begin
      if (cnt == '0) cnt <= RELOAD;
      else           cnt <= cnt - 1'b1;
      ref_pend <= (cnt == '0) | (ref_pend & ~clr);
    end
  end

endmodule

// File: rtl/ppc_sdram_ctrl.sv
// Single-beat byte access controller with periodic refresh.
// SDRAM_PARITY_EN adds DQ parity generation/check and the PERR output.
module ppc_sdram_ctrl
  import sdram_pkg::*;
#(
  parameter int T_RCD      = 2,
  parameter int CAS_LAT    = 2,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 4,
  parameter int REF_PERIOD = 780
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            RW,
  input  logic [0:20]     ADDR,
  input  logic [0:7]      WDATA,
  output logic [0:7]      RDATA,
  output logic            ACK,
  output logic            BUSY,
  output logic            CS,
  output logic            RAS,
  output logic            CAS,
  output logic            WE,
  output logic [0:11]     A,
  output logic [0:DQ_W-1] DQ_OUT,
  output logic            DQ_OE,
`ifdef SDRAM_PARITY_EN
  output logic            PERR,
`endif
  input  logic [0:DQ_W-1] DQ_IN
);

  localparam int CNT_W = 8;

  state_e           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [0:ROW_W-1] row_q;
  logic [0:COL_W-1] col_q;
  logic             rw_q;
  logic [0:7]       wd_q;

  cmd_t             cmd_n;
  logic [0:11]      a_n;
  logic [0:DQ_W-1]  dqo_n;
  logic             oe_n, ack_n, busy_n;
  logic             lat, sample, ref_clr, ref_pend;

  sdram_ref_timer #(.REF_PERIOD(REF_PERIOD)) u_ref (
    .CLK      (CLK),
    .RST      (RST),
    .clr      (ref_clr),
    .ref_pend (ref_pend)
  );

  always_comb begin
    state_n = state;
    cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
    lat     = 1'b0;
    sample  = 1'b0;
    ref_clr = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_pend) begin
          state_n = REF;
          ref_clr = 1'b1;
        end else if (REQ) begin
          state_n = ACT;
          cnt_n   = CNT_W'(T_RCD - 1);
          lat     = 1'b1;
        end
      end
      ACT: if (cnt == '0) state_n = COL;
      COL: begin
        state_n = rw_q ? CLW : WR;
        cnt_n   = CNT_W'(CAS_LAT - 1);
      end
      WR: begin
        state_n = PRE;
        cnt_n   = CNT_W'(T_RP - 1);
      end
      CLW: begin
        if (cnt == '0) begin
          state_n = PRE;
          cnt_n   = CNT_W'(T_RP - 1);
          sample  = 1'b1;
        end
      end
      PRE: if (cnt == '0) state_n = IDLE;
      REF: begin
        state_n = RFW;
        cnt_n   = CNT_W'(T_RFC - 1);
      end
      RFW: if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    cmd_n  = CMD_NOP;
    a_n    = A;
    dqo_n  = DQ_OUT;
    oe_n   = 1'b0;
    ack_n  = (state_n == PRE) && (cnt_n == '0);
    busy_n = (state_n != IDLE);
    unique case (state_n)
      ACT: begin
        cmd_n = CMD_ACTIVATE;
        a_n   = lat ? ADDR[0:11] : row_q;
      end
      COL: begin
        cmd_n = rw_q ? CMD_READ : CMD_WRITE;
        a_n   = {3'b000, col_q};
        if (!rw_q) begin
          oe_n = 1'b1;
`ifdef SDRAM_PARITY_EN
          dqo_n = {wd_q, even_par(wd_q)};
`else
          dqo_n = wd_q;
`endif
        end
      end
      WR: begin
        cmd_n = CMD_WDATA;
        oe_n  = 1'b1;
      end
      CLW:     cmd_n = CMD_WAIT;
      REF:     cmd_n = CMD_REFRESH;
      default: cmd_n = CMD_NOP;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      {CS, RAS, CAS, WE} <= CMD_NOP;
      A      <= '0;
      DQ_OUT <= '0;
      DQ_OE  <= 1'b0;
      RDATA  <= '0;
      ACK    <= 1'b0;
      BUSY   <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
      rw_q   <= 1'b0;
      wd_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      {CS, RAS, CAS, WE} <= cmd_n;
      A      <= a_n;
      DQ_OUT <= dqo_n;
      DQ_OE  <= oe_n;
      ACK    <= ack_n;
      BUSY   <= busy_n;
      if (lat) begin
        row_q <= ADDR[0:11];
        col_q <= ADDR[12:20];
        rw_q  <= RW;
        wd_q  <= WDATA;
      end
      if (sample) RDATA <= DQ_IN[0:7];
    end
  end

`ifdef SDRAM_PARITY_EN
  logic perr_q, bad_now;

  assign bad_now = even_par(DQ_IN[0:7]) != DQ_IN[8];

  always_ff @(posedge CLK) begin
    if (RST) begin
      perr_q <= 1'b0;
      PERR   <= 1'b0;
    end else begin
      if (sample) perr_q <= bad_now;
      PERR <= ack_n & rw_q & (sample ? bad_now : perr_q);
    end
  end
`endif

endmodule
